// File: rtl/class_argmax.sv
// ---------------------------------------------------------------------------
// class_argmax
//
// Streams N sign-magnitude class scores out of an upstream FIFO and reports
// the index and value of the largest one. Ties keep the lowest index, and
// +0 / -0 are treated as equal.
//
// Parameters
//   CLASS_W : width of the class count / class index (max N = 2^CLASS_W)
//   DATA_W  : width of a score; MSB is the sign, the rest is the magnitude
//
// Ports
//   clk_i          in   system clock, rising edge
//   rst_i          in   synchronous active-high reset (beats start_i)
//   start_i        in   one-cycle pulse: capture classes_i, begin a frame
//   classes_i      in   N-1, sampled only on start_i
//   fifo_rd_data_i in   score, valid one cycle after fifo_rd_en_o
//   fifo_empty_i   in   upstream FIFO empty flag
//   fifo_rd_en_o   out  upstream FIFO read request
//   result_class_o out  index of the winning class
//   result_score_o out  score of the winning class
//   result_valid_o out  result available, held until accepted
//   result_ready_i in   consumer accept
//   busy_o         out  high whenever the FSM is not IDLE
//   state_o        out  current FSM state (debug visibility)
//
// Result handshake: a result transfers on a rising edge where result_valid_o
// and result_ready_i are both high. Once result_valid_o rises it stays high,
// with class and score stable, until that transfer happens; it never drops
// without a transfer except on rst_i or a new start_i.
// ---------------------------------------------------------------------------
module class_argmax #(
    parameter int CLASS_W = 10,
    parameter int DATA_W  = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [CLASS_W-1:0] classes_i,
    input  logic [DATA_W-1:0]  fifo_rd_data_i,
    input  logic               fifo_empty_i,
    output logic               fifo_rd_en_o,
    output logic [CLASS_W-1:0] result_class_o,
    output logic [DATA_W-1:0]  result_score_o,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic               busy_o,
    output logic [1:0]         state_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [CLASS_W-1:0] CNT_ONE = {{(CLASS_W-1){1'b0}}, 1'b1};

    logic [1:0]         state;
    logic [CLASS_W-1:0] cfg_last;    // N-1 for the current frame
    logic [CLASS_W-1:0] rd_cnt;      // index of the next read to issue
    logic [CLASS_W-1:0] cap_cnt;     // index of the next score to capture
    logic               rd_en_q;     // read issued last cycle -> data valid now
    logic [DATA_W-1:0]  max_score;
    logic [CLASS_W-1:0] max_class;

    logic rd_en;
    logic final_read;
    logic cap_wins;
    logic accept;

    // Sign-magnitude "a strictly greater than b". A zero magnitude is
    // treated as non-negative regardless of its sign bit, so +0 == -0.
    function automatic logic sm_greater(input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b);
        logic [DATA_W-2:0] ma;
        logic [DATA_W-2:0] mb;
        logic              a_neg;
        logic              b_neg;
        logic              gt;
        ma    = a[DATA_W-2:0];
        mb    = b[DATA_W-2:0];
        a_neg = a[DATA_W-1] && (ma != '0);
        b_neg = b[DATA_W-1] && (mb != '0);
        if (a_neg != b_neg) begin
            gt = b_neg;          // non-negative beats negative
        end else if (!a_neg) begin
            gt = (ma > mb);      // both non-negative: larger magnitude
        end else begin
            gt = (ma < mb);      // both negative: smaller magnitude
        end
        return gt;
    endfunction

    // Reads stop by leaving READ on the last one, so rd_cnt never exceeds
    // N-1 while a read can issue. The request is also held off during a
    // reset or restart cycle so no FIFO entry is consumed and then discarded.
    assign rd_en      = (state == ST_READ) && !fifo_empty_i && !start_i && !rst_i;
    assign final_read = rd_en && (rd_cnt == cfg_last);

    // Index 0 always loads; later scores must be strictly greater.
    assign cap_wins   = (cap_cnt == '0) || sm_greater(fifo_rd_data_i, max_score);

    assign accept     = (state == ST_HOLD) && result_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            cfg_last  <= '0;
            rd_cnt    <= '0;
            cap_cnt   <= '0;
            rd_en_q   <= 1'b0;
            max_score <= '0;
            max_class <= '0;
        end else if (start_i) begin
            // Restart from any state; an in-flight read or unaccepted
            // result from the previous frame is dropped.
            state     <= ST_READ;
            cfg_last  <= classes_i;
            rd_cnt    <= '0;
            cap_cnt   <= '0;
            rd_en_q   <= 1'b0;
            max_score <= '0;
            max_class <= '0;
        end else begin
            rd_en_q <= rd_en;

            // The counter stays at N-1 on the final read so that
            // N = 2^CLASS_W does not wrap it.
            if (rd_en && !final_read) begin
                rd_cnt <= rd_cnt + CNT_ONE;
            end

            if (rd_en_q) begin
                if (cap_wins) begin
                    max_score <= fifo_rd_data_i;
                    max_class <= cap_cnt;
                end
                if (cap_cnt != cfg_last) begin
                    cap_cnt <= cap_cnt + CNT_ONE;
                end
            end

            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                ST_READ: begin
                    if (final_read) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The last score is captured during this cycle.
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (accept) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en_o   = rd_en;
    assign result_class_o = max_class;
    assign result_score_o = max_score;
    assign result_valid_o = (state == ST_HOLD);
    assign busy_o         = (state != ST_IDLE);
    assign state_o        = state;

endmodule

// File: doc/class_argmax.md
CLASS_ARGMAX -- requirements
Module: class_argmax

Interface
REQ-001 The block SHALL have parameter CLASS_W, default 10, which sets the width of the class count and class index.
REQ-002 The block SHALL have parameter DATA_W, default 8, which sets the width of a sign-magnitude score (MSB is the sign, remaining bits are the magnitude).
REQ-003 clk_i  input  1  single system clock; all logic is on the rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 start_i  input  1  one-cycle pulse: capture config and begin a new frame.
REQ-006 classes_i  input  CLASS_W  number of classes minus 1 (N-1); sampled only on start_i.
REQ-007 fifo_rd_data_i  input  DATA_W  score read from the upstream output FIFO; valid one cycle after fifo_rd_en_o.
REQ-008 fifo_empty_i  input  1  upstream FIFO empty flag.
REQ-009 fifo_rd_en_o  output  1  upstream FIFO read request.
REQ-010 result_class_o  output  CLASS_W  index of the winning class.
REQ-011 result_score_o  output  DATA_W  score of the winning class.
REQ-012 result_valid_o  output  1  result available; held until accepted.
REQ-013 result_ready_i  input  1  consumer accepts the result when high together with result_valid_o.
REQ-014 busy_o  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, READ, DRAIN and HOLD.
REQ-016 start_i in any state SHALL:
- register classes_i;
- clear the read counter, capture counter and running max;
- enter READ on the next cycle, aborting any frame in progress and dropping an un-accepted result.
REQ-017 In READ, fifo_rd_en_o SHALL be asserted combinationally when fifo_empty_i=0 and reads_issued <= N-1; it SHALL never be asserted while fifo_empty_i=1.
REQ-018 The read counter SHALL increment on each asserted fifo_rd_en_o. On the cycle the final read (index N-1) issues, the FSM SHALL move to DRAIN.
REQ-019 A one-cycle delayed copy of fifo_rd_en_o SHALL qualify capture of fifo_rd_data_i. The capture counter SHALL supply the class index of each captured score.
REQ-020 The first captured score (index 0) SHALL unconditionally load the running max and its index.
REQ-021 Each later score SHALL replace the running max only if it is strictly greater, so ties keep the lowest index.
REQ-022 Comparison SHALL be in sign-magnitude order:
- any positive value is greater than any negative value;
- among positives, larger magnitude wins;
- among negatives, smaller magnitude wins;
- +0 and -0 compare equal.
REQ-023 DRAIN SHALL last exactly one cycle, covering the capture of the last read, then enter HOLD.
REQ-024 In HOLD:
- result_valid_o SHALL be 1;
- result_class_o and result_score_o SHALL be stable;
- fifo_rd_en_o SHALL be 0.
REQ-025 When result_valid_o and result_ready_i are both high, the FSM SHALL return to IDLE next cycle, and result_valid_o SHALL be 0 from that cycle on.
REQ-026 With N=1 (classes_i=0), exactly one read SHALL issue, and that score with index 0 is the result.
REQ-027 Latency from the last fifo_rd_en_o to result_valid_o=1 SHALL be 2 cycles.
REQ-028 An empty FIFO in READ SHALL stall without timeout; counters hold their values.
REQ-029 The read and capture counters SHALL be CLASS_W bits wide and SHALL not wrap; the maximum supported N is 2^CLASS_W.
REQ-030 In IDLE, fifo_rd_en_o SHALL be 0 and upstream data SHALL be ignored.

Reset
REQ-031 When rst_i=1 at a clock edge, the next state SHALL be IDLE regardless of the current state, including mid-READ and mid-HOLD.
REQ-032 After reset:
- fifo_rd_en_o=0, result_valid_o=0, busy_o=0;
- result_class_o=0, result_score_o=0;
- all counters and the stored config = 0.
REQ-033 If rst_i and start_i are high in the same cycle, rst_i SHALL take priority.

Verification
REQ-034 Start with classes_i=3 and FIFO scores {0x05, 0x12, 0x7F, 0x12}, no stalls -> exactly 4 reads; result_class_o=2, result_score_o=0x7F; result_valid_o=1 two cycles after the 4th read.
REQ-035 Start with classes_i=2 and scores {0x83 (-3), 0x81 (-1), 0x85 (-5)} -> result_class_o=1, result_score_o=0x81.
REQ-036 Tie and zero cases:
- Scores {0x10, 0x10} with classes_i=1 -> result_class_o=0.
- Scores {0x80, 0x00} -> result_class_o=0 (+0 and -0 are equal).
REQ-037 fifo_empty_i toggles every other cycle, with N=5 -> fifo_rd_en_o is never high while empty, exactly 5 reads issue, and the result matches the no-stall run.
REQ-038 Hold result_ready_i=0 for 10 cycles in HOLD -> result_valid_o and outputs stay stable with no reads; raise ready -> IDLE next cycle, busy_o=0.
REQ-039 Mid-frame abort cases:
- rst_i pulsed after 2 of 4 reads -> IDLE with all outputs 0; a new start_i yields the correct result for the fresh frame.
- start_i pulsed after 2 of 4 reads -> the frame restarts, and the result uses only post-restart data.
